// File: rtl/uart_cmd_parser.sv
// Frames bytes from the UART receiver into HEADER/CMD/DATA/CHK commands and
// issues one registered strobe per good frame, checksum error, timeout or framing abort.
module uart_cmd_parser #(
    parameter logic [7:0]  HEADER      = 8'hD5,
    parameter int unsigned TIMEOUT_CYC = 52000,
    parameter int unsigned TO_W        = 16
) (
    input  logic        clkin,
    input  logic        manurst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_ferr,
    output logic [7:0]  cmd_out,
    output logic [7:0]  data_out,
    output logic        cmd_valid,
    output logic        chk_err,
    output logic        to_err,
    output logic        frm_err,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_CMD  = 2'd1,
        GET_DATA = 2'd2,
        GET_CHK  = 2'd3
    } state_t;

    // The timeout fires on the edge at which the counter would step to TIMEOUT_CYC-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 32'd2);

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
        return cmd ^ data;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [TO_W-1:0]  cnt_r;
    logic [7:0]       cmd_r;
    logic [7:0]       data_r;
    logic [7:0]       cmd_out_r;
    logic [7:0]       data_out_r;
    logic             cmd_valid_r;
    logic             chk_err_r;
    logic             to_err_r;
    logic             frm_err_r;
    logic             busy_r;
    logic [15:0]      frame_cnt_r;
    logic [7:0]       err_cnt_r;

    logic             accept_s;
    logic             ld_cmd_s;
    logic             ld_data_s;
    logic             good_s;
    logic             bad_s;
    logic             to_s;
    logic             frm_s;
    logic             err_s;

    // Next-state and event decode; rx_ferr outranks a coincident byte, a byte outranks the timeout.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        ld_cmd_s  = 1'b0;
        ld_data_s = 1'b0;
        good_s    = 1'b0;
        bad_s     = 1'b0;
        to_s      = 1'b0;
        frm_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_valid && (rx_data == HEADER)) begin
                    state_s = GET_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            GET_CMD, GET_DATA, GET_CHK: begin
                if (rx_ferr) begin
                    frm_s   = 1'b1;
                    state_s = IDLE;
                end else if (rx_valid) begin
                    accept_s = 1'b1;
                    case (state_r)
                        GET_CMD: begin
                            ld_cmd_s = 1'b1;
                            state_s  = GET_DATA;
                        end
                        GET_DATA: begin
                            ld_data_s = 1'b1;
                            state_s   = GET_CHK;
                        end
                        GET_CHK: begin
                            state_s = IDLE;
                            if (rx_data == frame_chk(cmd_r, data_r)) begin
                                good_s = 1'b1;
                            end else begin
                                bad_s = 1'b1;
                            end
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else if (cnt_r == TO_LAST) begin
                    to_s    = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        err_s = bad_s | to_s | frm_s;
    end

    // State register.
    always_ff @(posedge clkin) begin
        if (manurst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Inter-byte counter: zero in IDLE, on every accepted byte and when the frame ends.
    always_ff @(posedge clkin) begin
        if (manurst) begin
            cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == IDLE) || accept_s || (state_s == IDLE)) begin
            cnt_r <= {TO_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    // Payload capture for the frame in progress.
    always_ff @(posedge clkin) begin
        if (manurst) begin
            cmd_r  <= 8'h00;
            data_r <= 8'h00;
        end else begin
            if (ld_cmd_s) begin
                cmd_r <= rx_data;
            end
            if (ld_data_s) begin
                data_r <= rx_data;
            end
        end
    end

    // Registered strobes and busy flag; at most one strobe is ever set per cycle.
    always_ff @(posedge clkin) begin
        if (manurst) begin
            cmd_valid_r <= 1'b0;
            chk_err_r   <= 1'b0;
            to_err_r    <= 1'b0;
            frm_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cmd_valid_r <= good_s;
            chk_err_r   <= bad_s;
            to_err_r    <= to_s;
            frm_err_r   <= frm_s;
            busy_r      <= (state_s != IDLE);
        end
    end

    // Last good command, wrapping frame count and saturating error count.
    always_ff @(posedge clkin) begin
        if (manurst) begin
            cmd_out_r   <= 8'h00;
            data_out_r  <= 8'h00;
            frame_cnt_r <= 16'h0000;
            err_cnt_r   <= 8'h00;
        end else begin
            if (good_s) begin
                cmd_out_r   <= cmd_r;
                data_out_r  <= data_r;
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            if (err_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign cmd_out   = cmd_out_r;
    assign data_out  = data_out_r;
    assign cmd_valid = cmd_valid_r;
    assign chk_err   = chk_err_r;
    assign to_err    = to_err_r;
    assign frm_err   = frm_err_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule
